tti_feed_ctrl: RTL and testbench

Sequencer that drives the DJS130 teletype-input (TTI) device from a host byte stream. It buffers bytes from a UART receiver in a small FIFO. It hands one byte at a time to the TTI data/write port, but only while the CPU has the device started (BUSY), and then waits for the device to raise DONE before releasing the next byte. It sits between the host UART receiver and the TTI device, in the same clock domain as the I/O bus logic.

---
 rtl/tti_feed_pkg.sv | 24 ++
 rtl/tti_feed_ctrl_if.sv | 37 +++
 rtl/tti_feed_fifo.sv | 79 +++++++
 rtl/tti_feed_ctrl.sv | 133 +++++++++++++
 tb/tb_tti_feed_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tti_feed_pkg.sv
// ============================================================================
// tti_feed_pkg : shared state encoding and defaults for the TTI feed sequencer
// Revision     : 1.0
// ============================================================================
`default_nettype none

package tti_feed_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   localparam int          c_DEPTH_DFLT   = 8;
   localparam int          c_AFULL_DFLT   = 6;
   localparam int          c_GAP_DFLT     = 16;
   localparam int          c_TIMEOUT_DFLT = 255;
   localparam logic [7:0]  c_DATA_RST     = 8'h00;

endpackage

`default_nettype wire

// File: rtl/tti_feed_ctrl_if.sv
// ============================================================================
// tti_feed_ctrl_if : host-byte / TTI-device signal bundle for tti_feed_ctrl
// Revision         : 1.0
// ============================================================================
`default_nettype none

interface tti_feed_ctrl_if
   import tti_feed_pkg::*;
#(
   parameter int DEPTH = c_DEPTH_DFLT
) ();

   logic                     i_rx_valid;
   logic [7:0]               i_rx_data;
   logic                     i_tti_busy;
   logic                     i_tti_done;
   logic                     i_clr_err;
   logic                     o_write;
   logic [7:0]               o_data;
   logic                     o_rts;
   logic [$clog2(DEPTH):0]   o_count;
   logic                     o_ovf;
   logic                     o_tmo;

   modport master (
      output i_rx_valid, i_rx_data, i_tti_busy, i_tti_done, i_clr_err,
      input  o_write, o_data, o_rts, o_count, o_ovf, o_tmo
   );

   modport slave (
      input  i_rx_valid, i_rx_data, i_tti_busy, i_tti_done, i_clr_err,
      output o_write, o_data, o_rts, o_count, o_ovf, o_tmo
   );

endinterface

`default_nettype wire

// File: rtl/tti_feed_fifo.sv
// ============================================================================
// tti_feed_fifo : byte FIFO with registered occupancy and almost-full RTS
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tti_feed_fifo #(
   parameter int DEPTH = 8,
   parameter int AFULL = 6
) (
   input  logic                     i_clk,
   input  logic                     i_ZZ0,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [7:0]               wdata_i,
   output logic [7:0]               rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     rts_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          rts_q;
   logic          wr_en;
   logic          rd_en;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign rd_en   = pop_i && !empty_o;
   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   assign wr_en   = push_i && (!full_o || rd_en);
   assign rdata_o = mem_q[rd_q];
   assign count_o = count_q;
   assign rts_o   = rts_q;

   always_comb begin
      count_d = count_q;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem_q[wr_q] <= wdata_i;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_ZZ0) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         rts_q   <= 1'b1;
      end else begin
         if (wr_en) begin
            wr_q <= wr_q + AW'(1);
         end
         if (rd_en) begin
            rd_q <= rd_q + AW'(1);
         end
         count_q <= count_d;
         rts_q   <= (count_d < CW'(AFULL));
      end
   end

endmodule

`default_nettype wire

// File: rtl/tti_feed_ctrl.sv
// ============================================================================
// tti_feed_ctrl : feeds host bytes one at a time into the DJS130 TTI device.
// Optional macro TTI_PARITY_STRIP_EN clears bit 7 of each byte handed over.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tti_feed_ctrl
   import tti_feed_pkg::*;
#(
   parameter int DEPTH   = c_DEPTH_DFLT,
   parameter int AFULL   = c_AFULL_DFLT,
   parameter int GAP     = c_GAP_DFLT,
   parameter int TIMEOUT = c_TIMEOUT_DFLT
) (
   input  logic            i_clk,
   input  logic            i_ZZ0,
   tti_feed_ctrl_if.slave  bus
);

   localparam int              TW         = $clog2(TIMEOUT + 1);
   localparam int              GW         = $clog2(GAP + 1);
   localparam logic [TW-1:0]   c_TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0]   c_GAP_LOAD = GW'(GAP - 1);

   state_e        state_q;
   logic          write_q;
   logic [7:0]    data_q;
   logic [TW-1:0] timer_q;
   logic [GW-1:0] gap_q;
   logic          ovf_q;
   logic          tmo_q;

   logic          pop;
   logic          drop;
   logic          full;
   logic          empty;
   logic [7:0]    head;
   logic [7:0]    payload;

   assign pop  = (state_q == ST_IDLE) && bus.i_tti_busy && !empty;
   assign drop = bus.i_rx_valid && full && !pop;

`ifdef TTI_PARITY_STRIP_EN
   assign payload = head & 8'h7F;
`else
   assign payload = head;
`endif

   tti_feed_fifo #(
      .DEPTH   (DEPTH),
      .AFULL   (AFULL)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_ZZ0   (i_ZZ0),
      .push_i  (bus.i_rx_valid),
      .pop_i   (pop),
      .wdata_i (bus.i_rx_data),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (bus.o_count),
      .rts_o   (bus.o_rts)
   );

   assign bus.o_write = write_q;
   assign bus.o_data  = data_q;
   assign bus.o_ovf   = ovf_q;
   assign bus.o_tmo   = tmo_q;

   always_ff @(posedge i_clk) begin
      if (i_ZZ0) begin
         state_q <= ST_IDLE;
         write_q <= 1'b0;
         data_q  <= c_DATA_RST;
         timer_q <= '0;
         gap_q   <= '0;
         ovf_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         write_q <= 1'b0;
         // Clear first so a set event later in this block takes precedence.
         if (bus.i_clr_err) begin
            ovf_q <= 1'b0;
            tmo_q <= 1'b0;
         end
         if (drop) begin
            ovf_q <= 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  data_q  <= payload;
                  write_q <= 1'b1;
                  state_q <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               timer_q <= '0;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.i_tti_done) begin
                  gap_q   <= c_GAP_LOAD;
                  state_q <= ST_GAP;
               end else if (!bus.i_tti_busy) begin
                  // CPU cleared the device: the byte is treated as consumed.
                  gap_q   <= c_GAP_LOAD;
                  state_q <= ST_GAP;
               end else if (timer_q == c_TMO_LAST) begin
                  tmo_q   <= 1'b1;
                  gap_q   <= c_GAP_LOAD;
                  state_q <= ST_GAP;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            ST_GAP: begin
               if (gap_q == '0) begin
                  state_q <= ST_IDLE;
               end else begin
                  gap_q <= gap_q - GW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_tti_feed_ctrl.sv
// ============================================================================
// tb_tti_feed_ctrl : vector-table and directed-sequence bench for tti_feed_ctrl
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_tti_feed_ctrl;

   localparam int DEPTH   = 8;
   localparam int AFULL   = 6;
   localparam int GAP     = 16;
   localparam int TIMEOUT = 255;

`ifdef TTI_PARITY_STRIP_EN
   localparam logic [7:0] PAR_C1 = 8'h41;
`else
   localparam logic [7:0] PAR_C1 = 8'hC1;
`endif

   typedef struct {
      logic       rst;
      logic       v;
      logic [7:0] d;
      logic       busy;
      logic       done;
      logic       clr;
      logic       wr;
      logic [7:0] dat;
      logic [3:0] cnt;
      logic       rts;
      logic       ovf;
      logic       tmo;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   vec_t tbl[$];

   tti_feed_ctrl_if #(.DEPTH(DEPTH)) bus ();

   tti_feed_ctrl #(
      .DEPTH   (DEPTH),
      .AFULL   (AFULL),
      .GAP     (GAP),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .i_clk (clk),
      .i_ZZ0 (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic wait_write(input int lim, output bit found);
      found = 1'b0;
      for (int i = 0; i < lim; i++) begin
         step();
         if (bus.o_write === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                               input logic busy, input logic done, input logic clr,
                               input logic wr, input logic [7:0] dat, input logic [3:0] cnt,
                               input logic rts, input logic ovf, input logic tmo);
      vec_t x;
      x.rst = r; x.v = v; x.d = d; x.busy = busy; x.done = done; x.clr = clr;
      x.wr = wr; x.dat = dat; x.cnt = cnt; x.rts = rts; x.ovf = ovf; x.tmo = tmo;
      return x;
   endfunction

   initial begin
      bit         found;
      int         np;
      int         t;
      int         nw;
      int         tp [3];
      logic [7:0] dp [3];

      bus.i_rx_valid = 1'b0;
      bus.i_rx_data  = 8'h00;
      bus.i_tti_busy = 1'b0;
      bus.i_tti_done = 1'b0;
      bus.i_clr_err  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tp[i] = 0;
         dp[i] = 8'h00;
      end

      // reset state
      tbl.push_back(mk(1,0,8'h00,0,0,0, 0,8'h00,4'd0,1,0,0));
      // basic handoff: strobe two edges after push, DONE releases into GAP
      tbl.push_back(mk(0,1,8'h41,1,0,0, 0,8'h00,4'd1,1,0,0));
      tbl.push_back(mk(0,0,8'h00,1,0,0, 1,8'h41,4'd0,1,0,0));
      tbl.push_back(mk(0,0,8'h00,1,1,0, 0,8'h41,4'd0,1,0,0));
      tbl.push_back(mk(0,0,8'h00,1,1,0, 0,8'h41,4'd0,1,0,0));
      for (int i = 0; i < GAP; i++)
         tbl.push_back(mk(0,0,8'h00,1,0,0, 0,8'h41,4'd0,1,0,0));
      // overflow with BUSY low
      for (int k = 1; k <= 9; k++) begin
         int c;
         c = (k > DEPTH) ? DEPTH : k;
         tbl.push_back(mk(0,1,8'(k),0,0,0, 0,8'h41,4'(c),(c < AFULL),(k > DEPTH),0));
      end
      tbl.push_back(mk(0,0,8'h00,0,0,1, 0,8'h41,4'd8,0,0,0));
      tbl.push_back(mk(0,1,8'hAA,0,0,1, 0,8'h41,4'd8,0,1,0));
      tbl.push_back(mk(0,0,8'h00,0,0,1, 0,8'h41,4'd8,0,0,0));
      // pop and push together while full: occupancy stays at DEPTH
      tbl.push_back(mk(0,1,8'hBB,1,0,0, 1,8'h01,4'd8,0,0,0));
      tbl.push_back(mk(0,0,8'h00,1,0,0, 0,8'h01,4'd8,0,0,0));
      tbl.push_back(mk(0,0,8'h00,1,0,0, 0,8'h01,4'd8,0,0,0));
      // reset during WAIT, then FIFO must be empty
      tbl.push_back(mk(1,0,8'h00,1,0,0, 0,8'h00,4'd0,1,0,0));
      tbl.push_back(mk(0,0,8'h00,0,0,0, 0,8'h00,4'd0,1,0,0));
      // parity option
      tbl.push_back(mk(0,1,8'hC1,1,0,0, 0,8'h00,4'd1,1,0,0));
      tbl.push_back(mk(0,0,8'h00,1,0,0, 1,PAR_C1,4'd0,1,0,0));
      tbl.push_back(mk(0,0,8'h00,1,1,0, 0,PAR_C1,4'd0,1,0,0));
      tbl.push_back(mk(0,0,8'h00,1,1,0, 0,PAR_C1,4'd0,1,0,0));

      foreach (tbl[i]) begin
         rst            = tbl[i].rst;
         bus.i_rx_valid = tbl[i].v;
         bus.i_rx_data  = tbl[i].d;
         bus.i_tti_busy = tbl[i].busy;
         bus.i_tti_done = tbl[i].done;
         bus.i_clr_err  = tbl[i].clr;
         step();
         check($sformatf("vec%0d", i),
               32'({bus.o_write, bus.o_data, bus.o_count, bus.o_rts, bus.o_ovf, bus.o_tmo}),
               32'({tbl[i].wr, tbl[i].dat, tbl[i].cnt, tbl[i].rts, tbl[i].ovf, tbl[i].tmo}));
      end
      rst = 1'b0; bus.i_rx_valid = 1'b0; bus.i_tti_busy = 1'b0;
      bus.i_tti_done = 1'b0; bus.i_clr_err = 1'b0;
      repeat (GAP + 5) step();

      // back-to-back: DONE held high, spacing is exactly GAP+3
      for (int k = 0; k < 3; k++) begin
         bus.i_rx_valid = 1'b1;
         bus.i_rx_data  = 8'h41 + 8'(k);
         step();
      end
      bus.i_rx_valid = 1'b0;
      bus.i_tti_busy = 1'b1;
      bus.i_tti_done = 1'b1;
      np = 0;
      for (int i = 0; i < 120 && np < 3; i++) begin
         step();
         if (bus.o_write === 1'b1) begin
            tp[np] = cyc;
            dp[np] = bus.o_data;
            np++;
         end
      end
      check("b2b_pulses", 32'(np), 32'd3);
      check("b2b_data0", 32'(dp[0]), 32'h41);
      check("b2b_data1", 32'(dp[1]), 32'h42);
      check("b2b_data2", 32'(dp[2]), 32'h43);
      check("b2b_space01", 32'(tp[1] - tp[0]), 32'(GAP + 3));
      check("b2b_space12", 32'(tp[2] - tp[1]), 32'(GAP + 3));
      check("b2b_count", 32'(bus.o_count), 32'd0);
      bus.i_tti_done = 1'b0;
      bus.i_tti_busy = 1'b0;
      repeat (GAP + 5) step();

      // CPU clears device mid-WAIT: no retry, no timeout
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = 8'h55;
      bus.i_tti_busy = 1'b1;
      step();
      bus.i_rx_valid = 1'b0;
      wait_write(10, found);
      check("clr_strobe", 32'(found), 32'd1);
      check("clr_data", 32'(bus.o_data), 32'h55);
      bus.i_tti_busy = 1'b0;
      nw = 0;
      repeat (40) begin
         step();
         if (bus.o_write === 1'b1) nw++;
      end
      bus.i_tti_busy = 1'b1;
      repeat (40) begin
         step();
         if (bus.o_write === 1'b1) nw++;
      end
      check("clr_no_resend", 32'(nw), 32'd0);
      check("clr_tmo", 32'(bus.o_tmo), 32'd0);
      check("clr_count", 32'(bus.o_count), 32'd0);

      // timeout: WAIT lasts exactly TIMEOUT cycles, then GAP and back to IDLE
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = 8'h66;
      step();
      bus.i_rx_valid = 1'b0;
      wait_write(10, found);
      check("tmo_strobe", 32'(found), 32'd1);
      t = cyc;
      while (cyc < t + TIMEOUT) step();
      check("tmo_before", 32'(bus.o_tmo), 32'd0);
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = 8'h77;
      step();
      bus.i_rx_valid = 1'b0;
      check("tmo_set", 32'(bus.o_tmo), 32'd1);
      wait_write(GAP + 10, found);
      check("tmo_next_strobe", 32'(found), 32'd1);
      check("tmo_next_time", 32'(cyc), 32'(t + TIMEOUT + 1 + GAP + 1));
      check("tmo_next_data", 32'(bus.o_data), 32'h77);
      bus.i_tti_done = 1'b1;
      step();
      step();
      bus.i_tti_done = 1'b0;
      check("tmo_sticky", 32'(bus.o_tmo), 32'd1);
      bus.i_clr_err = 1'b1;
      step();
      bus.i_clr_err = 1'b0;
      check("tmo_cleared", 32'(bus.o_tmo), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
